// File: rtl/motion_pkg.sv
// motion_pkg: shared scheduler state encoding and default screen/step geometry.
package motion_pkg;
   typedef enum logic [1:0] {IDLE, ARB, APPLY} state_t;
   localparam int MOTION_STEP_W = 4;
   localparam int MOTION_X_MAX  = 639;
   localparam int MOTION_Y_MAX  = 479;
endpackage

// File: rtl/motion_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_idx
);
   localparam int IW = $clog2(NREQ);
   logic          found;
   logic [IW-1:0] idx;
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IW'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx;
         end
      end
   end
endmodule

// File: rtl/motion_scheduler.sv
// motion_scheduler: round-robin slot scheduler applying signed steps to a shared ball position.
// Define MOTION_WRAP_EN for torus-screen wrapping instead of edge clamping.
module motion_scheduler
   import motion_pkg::*;
#(
   parameter int NREQ       = 3,
   parameter int TICK_COUNT = 250_000,
   parameter int POS_W      = 16,
   parameter int STEP_W     = MOTION_STEP_W,
   parameter int X_MAX      = MOTION_X_MAX,
   parameter int Y_MAX      = MOTION_Y_MAX,
   parameter int X_INIT     = 320,
   parameter int Y_INIT     = 240
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*STEP_W-1:0]   dx,
   input  logic [NREQ*STEP_W-1:0]   dy,
   input  logic                     hold,
   output logic [NREQ-1:0]          ack,
   output logic [POS_W-1:0]         x_pos,
   output logic [POS_W-1:0]         y_pos,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     upd_valid,
   output logic [3:0]               edge_hit
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TICK_COUNT);

   // Returns {hit_high, hit_low, new_pos}; the sum is two bits wider so sign and overflow are visible.
   function automatic logic [POS_W+1:0] axis_upd(input logic [POS_W-1:0] pos,
                                                 input logic [STEP_W-1:0] step,
                                                 input logic [POS_W-1:0] lim);
      logic [POS_W+1:0] sum;
      logic             lo, hi;
      sum = {2'b00, pos} + {{(POS_W+2-STEP_W){step[STEP_W-1]}}, step};
      lo  = sum[POS_W+1];
      hi  = !lo && (sum > {2'b00, lim});
`ifdef MOTION_WRAP_EN
      axis_upd = {hi, lo, lo ? sum[POS_W-1:0] + lim + 1'b1 : hi ? sum[POS_W-1:0] - lim - 1'b1 : sum[POS_W-1:0]};
`else
      axis_upd = {hi, lo, lo ? {POS_W{1'b0}} : hi ? lim : sum[POS_W-1:0]};
`endif
   endfunction

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       ptr_q, ptr_d, gid_q, gid_d;
   logic [STEP_W-1:0]   sx_q, sx_d, sy_q, sy_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic                upd_q, upd_d;
   logic [POS_W-1:0]    x_q, x_d, y_q, y_d;
   logic [3:0]          edge_q, edge_d;
   logic [NREQ-1:0]     gnt;
   logic [IW-1:0]       gnt_idx;
   logic                tick;
   logic [POS_W+1:0]    xr, yr;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      tick    = cnt_q == CW'(TICK_COUNT - 1);
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      xr      = axis_upd(x_q, sx_q, POS_W'(X_MAX));
      yr      = axis_upd(y_q, sy_q, POS_W'(Y_MAX));
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      ack_d   = '0;
      upd_d   = 1'b0;
      x_d     = x_q;
      y_d     = y_q;
      edge_d  = edge_q;
      case (state_q)
         IDLE: state_d = (tick && !hold && |req) ? ARB : IDLE;
         ARB: begin
            state_d = |req ? APPLY : IDLE;
            if (|req) begin
               gid_d = gnt_idx;
               ack_d = gnt;
               upd_d = 1'b1;
               for (int i = 0; i < NREQ; i++) begin
                  if (gnt[i]) begin
                     sx_d = dx[i*STEP_W +: STEP_W];
                     sy_d = dy[i*STEP_W +: STEP_W];
                  end
               end
            end
         end
         APPLY: begin
            state_d = IDLE;
            x_d     = xr[POS_W-1:0];
            y_d     = yr[POS_W-1:0];
            edge_d  = {xr[POS_W+1], xr[POS_W], yr[POS_W+1], yr[POS_W]};
            ptr_d   = gid_q == IW'(NREQ - 1) ? '0 : gid_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         gid_q   <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         ack_q   <= '0;
         upd_q   <= 1'b0;
         x_q     <= POS_W'(X_INIT);
         y_q     <= POS_W'(Y_INIT);
         edge_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         ack_q   <= ack_d;
         upd_q   <= upd_d;
         x_q     <= x_d;
         y_q     <= y_d;
         edge_q  <= edge_d;
      end
   end

   assign ack       = ack_q;
   assign upd_valid = upd_q;
   assign grant_id  = gid_q;
   assign x_pos     = x_q;
   assign y_pos     = y_q;
   assign edge_hit  = edge_q;
endmodule

// File: tb/tb_motion_scheduler.sv
// tb_motion_scheduler: directed slot-by-slot checks of grant order, stepping, edges, hold and reset abort.
module tb_motion_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = '0;
   logic [11:0] dx = '0, dy = '0;
   logic        hold = 1'b0;
   logic [2:0]  ack;
   logic [15:0] x_pos, y_pos;
   logic [1:0]  grant_id;
   logic        upd_valid;
   logic [3:0]  edge_hit;
   int          checks = 0, failures = 0;
   int          ex, ey;

   always #5 clk = ~clk;

   motion_scheduler #(.NREQ(3), .TICK_COUNT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .dx        (dx),
      .dy        (dy),
      .hold      (hold),
      .ack       (ack),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .grant_id  (grant_id),
      .upd_valid (upd_valid),
      .edge_hit  (edge_hit)
   );

   typedef struct {
      string       nm;
      logic [2:0]  req;
      logic [11:0] dx, dy;
      logic        hold;
      logic [2:0]  ack;
      logic [15:0] x, y;
      logic [3:0]  eh;
      logic [1:0]  gid;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Entered in the counter==TICK_COUNT-2 cycle; the tick follows, ack at +2, position at +3.
   task automatic slot(input vec_t v);
      logic stray;
      stray = 1'b0;
      req  = v.req;
      dx   = v.dx;
      dy   = v.dy;
      hold = v.hold;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) begin
            chk({v.nm, " ack"}, 32'(ack), 32'(v.ack));
            chk({v.nm, " upd_valid"}, 32'(upd_valid), 32'(|v.ack));
            if (v.ack != 3'b000) chk({v.nm, " grant_id"}, 32'(grant_id), 32'(v.gid));
         end else begin
            stray = stray | (ack != 3'b000) | upd_valid;
         end
      end
      chk({v.nm, " stray pulse"}, 32'(stray), 32'd0);
      chk({v.nm, " x_pos"}, 32'(x_pos), 32'(v.x));
      chk({v.nm, " y_pos"}, 32'(y_pos), 32'(v.y));
      chk({v.nm, " edge_hit"}, 32'(edge_hit), 32'(v.eh));
   endtask

   task automatic align_after_release();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0]  = '{"idle0", 3'b000, 12'h000, 12'h000, 1'b0, 3'b000, 16'd320, 16'd240, 4'h0, 2'd0};
      vt[1]  = '{"idle1", 3'b000, 12'h111, 12'h111, 1'b0, 3'b000, 16'd320, 16'd240, 4'h0, 2'd0};
      vt[2]  = '{"idle2", 3'b000, 12'h000, 12'h000, 1'b0, 3'b000, 16'd320, 16'd240, 4'h0, 2'd0};
      vt[3]  = '{"rr0",   3'b111, 12'h111, 12'h000, 1'b0, 3'b001, 16'd321, 16'd240, 4'h0, 2'd0};
      vt[4]  = '{"rr1",   3'b111, 12'h111, 12'h000, 1'b0, 3'b010, 16'd322, 16'd240, 4'h0, 2'd1};
      vt[5]  = '{"rr2",   3'b111, 12'h111, 12'h000, 1'b0, 3'b100, 16'd323, 16'd240, 4'h0, 2'd2};
      vt[6]  = '{"rr3",   3'b111, 12'h111, 12'h000, 1'b0, 3'b001, 16'd324, 16'd240, 4'h0, 2'd0};
      vt[7]  = '{"rr4",   3'b111, 12'h111, 12'h000, 1'b0, 3'b010, 16'd325, 16'd240, 4'h0, 2'd1};
      vt[8]  = '{"rr5",   3'b111, 12'h111, 12'h000, 1'b0, 3'b100, 16'd326, 16'd240, 4'h0, 2'd2};
      vt[9]  = '{"lane1", 3'b110, 12'h3E5, 12'h151, 1'b0, 3'b010, 16'd324, 16'd245, 4'h0, 2'd1};
      vt[10] = '{"wrap0", 3'b011, 12'h9F3, 12'h22C, 1'b0, 3'b001, 16'd327, 16'd241, 4'h0, 2'd0};
      vt[11] = '{"lane2", 3'b101, 12'h7A1, 12'h8B2, 1'b0, 3'b100, 16'd334, 16'd233, 4'h0, 2'd2};

      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset ack", 32'(ack), 32'd0);
      chk("reset upd_valid", 32'(upd_valid), 32'd0);
      chk("reset x_pos", 32'(x_pos), 32'd320);
      chk("reset y_pos", 32'(y_pos), 32'd240);
      chk("reset grant_id", 32'(grant_id), 32'd0);
      chk("reset edge_hit", 32'(edge_hit), 32'd0);
      rst = 1'b0;
      align_after_release();

      for (int i = 0; i < 12; i++) slot(vt[i]);

      ex = 334;
      ey = 233;
      for (int i = 0; i < 43; i++) begin
         ex += 7;
         slot('{"climb", 3'b001, 12'h007, 12'h000, 1'b0, 3'b001, 16'(ex), 16'(ey), 4'h0, 2'd0});
      end
      ex += 3;
      slot('{"x638", 3'b001, 12'h003, 12'h000, 1'b0, 3'b001, 16'(ex), 16'(ey), 4'h0, 2'd0});
`ifdef MOTION_WRAP_EN
      ex = 2;
`else
      ex = 639;
`endif
      slot('{"right edge", 3'b001, 12'h004, 12'h000, 1'b0, 3'b001, 16'(ex), 16'(ey), 4'b1000, 2'd0});

      for (int i = 0; i < 29; i++) begin
         ey -= 8;
         slot('{"descend", 3'b001, 12'h000, 12'h008, 1'b0, 3'b001, 16'(ex), 16'(ey), 4'h0, 2'd0});
      end
`ifdef MOTION_WRAP_EN
      ey = 478;
`else
      ey = 0;
`endif
      slot('{"top edge", 3'b001, 12'h000, 12'h00D, 1'b0, 3'b001, 16'(ex), 16'(ey), 4'b0001, 2'd0});
      slot('{"zero step", 3'b001, 12'h000, 12'h000, 1'b0, 3'b001, 16'(ex), 16'(ey), 4'h0, 2'd0});

      slot('{"hold a", 3'b001, 12'h00F, 12'h000, 1'b1, 3'b000, 16'(ex), 16'(ey), 4'h0, 2'd0});
      slot('{"hold b", 3'b001, 12'h00F, 12'h000, 1'b1, 3'b000, 16'(ex), 16'(ey), 4'h0, 2'd0});
      ex -= 1;
      slot('{"unhold", 3'b001, 12'h00F, 12'h000, 1'b0, 3'b001, 16'(ex), 16'(ey), 4'h0, 2'd0});

      req  = 3'b111;
      dx   = 12'h000;
      dy   = 12'h000;
      hold = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort ack", 32'(ack), 32'd0);
      chk("abort upd_valid", 32'(upd_valid), 32'd0);
      chk("abort x_pos", 32'(x_pos), 32'd320);
      chk("abort y_pos", 32'(y_pos), 32'd240);
      @(posedge clk);
      #1;
      chk("abort held ack", 32'(ack), 32'd0);
      rst = 1'b0;
      align_after_release();
      slot('{"post reset", 3'b111, 12'h221, 12'h000, 1'b0, 3'b001, 16'd321, 16'd240, 4'h0, 2'd0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
